// File: rtl/fp_add_pkg.sv
// Shared types and default sizes for the sequential floating-point adder.
package fp_add_pkg;

  localparam int unsigned EXP_W_DEF  = 8;
  localparam int unsigned FRAC_W_DEF = 23;
  // Extended mantissa: hidden bit + fraction + guard/round/sticky
  localparam int unsigned MW_DEF     = FRAC_W_DEF + 4;
  // Largest alignment distance carried through; anything beyond collapses to sticky
  localparam int unsigned SHIFT_SAT  = 63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fp_align_shift.sv
// Right shifter for mantissa alignment; reports OR of all bits shifted out.
module fp_align_shift
  import fp_add_pkg::*;
#(
  parameter int unsigned MW = MW_DEF
) (
  input  logic [MW-1:0] data_i,
  input  logic [5:0]    amt_i,
  output logic [MW-1:0] data_o,
  output logic          sticky_o
);

  // Shifts of MW or more flush the value entirely into sticky
  always_comb begin
    data_o   = '0;
    sticky_o = |data_i;
    if (32'(amt_i) < MW) begin
      data_o   = data_i >> amt_i;
      sticky_o = |(data_i & ~({MW{1'b1}} << amt_i));
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder: unpack, align, add, normalise one step per cycle.
// Optional feature macro: FP_ADD_SEQ_ZERO_BYPASS_EN (zero operand short-cut).
module fp_add_seq
  import fp_add_pkg::*;
#(
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [EXP_W+FRAC_W:0]   in_a,
  input  logic [EXP_W+FRAC_W:0]   in_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic [EXP_W-1:0]        out_exp,
  output logic [FRAC_W+3:0]       out_mant,
  output logic                    out_ovf,
  output logic                    busy
);

  localparam int unsigned MW = FRAC_W + 4;

  state_e            state_q, state_d;
  logic [MW-1:0]     big_q, big_d, small_q, small_d;
  logic [5:0]        diff_q, diff_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic              sign_q, sign_d, sub_q, sub_d, zsign_q, zsign_d, byp_q, byp_d;
  logic [MW:0]       sum_q, sum_d;
  logic              ovf_q, in_ready_q, out_valid_q, busy_q;

  logic              sa, sb, a_big, sh_sticky;
  logic [EXP_W-1:0]  ea, eb, eff_a, eff_b, diff_full;
  logic [FRAC_W-1:0] fa, fb;
  logic [MW-1:0]     mant_a, mant_b, sh_data;
  logic [5:0]        diff_sat;
`ifdef FP_ADD_SEQ_ZERO_BYPASS_EN
  logic              zero_a, zero_b;
`endif

  // Operand unpack, magnitude compare and saturated exponent difference
  always_comb begin
    {sa, ea, fa} = in_a;
    {sb, eb, fb} = in_b;
    mant_a    = {(ea != '0), fa, 3'b000};
    mant_b    = {(eb != '0), fb, 3'b000};
    eff_a     = (ea == '0) ? EXP_W'(1) : ea;
    eff_b     = (eb == '0) ? EXP_W'(1) : eb;
    a_big     = (ea > eb) || ((ea == eb) && (fa >= fb));
    diff_full = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
    diff_sat  = (32'(diff_full) > SHIFT_SAT) ? 6'(SHIFT_SAT) : 6'(diff_full);
  end

`ifdef FP_ADD_SEQ_ZERO_BYPASS_EN
  assign zero_a = (ea == '0) && (fa == '0);
  assign zero_b = (eb == '0) && (fb == '0);
`endif

  fp_align_shift #(.MW(MW)) u_align (
    .data_i   (small_q),
    .amt_i    (diff_q),
    .data_o   (sh_data),
    .sticky_o (sh_sticky)
  );

  // Next-state and datapath update for each FSM phase
  always_comb begin
    state_d = state_q;
    big_d   = big_q;
    small_d = small_q;
    diff_d  = diff_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    zsign_d = zsign_q;
    sum_d   = sum_q;
    byp_d   = byp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_ALIGN;
          byp_d   = 1'b0;
          sub_d   = sa ^ sb;
          zsign_d = sa & sb;
          diff_d  = diff_sat;
          if (a_big) begin
            big_d = mant_a; small_d = mant_b; exp_d = eff_a; sign_d = sa;
          end else begin
            big_d = mant_b; small_d = mant_a; exp_d = eff_b; sign_d = sb;
          end
`ifdef FP_ADD_SEQ_ZERO_BYPASS_EN
          // Zero operand: result is the other operand, ALIGN only passes through
          if (zero_a) begin
            byp_d  = 1'b1;
            sum_d  = {1'b0, mant_b};
            exp_d  = eb;
            sign_d = zero_b ? (sa & sb) : sb;
          end else if (zero_b) begin
            byp_d  = 1'b1;
            sum_d  = {1'b0, mant_a};
            exp_d  = ea;
            sign_d = sa;
          end
`endif
        end
      end
      ST_ALIGN: begin
        if (byp_q) begin
          state_d = ST_DONE;
        end else begin
          small_d = {sh_data[MW-1:1], sh_data[0] | sh_sticky};
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        sum_d   = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                        : ({1'b0, big_q} + {1'b0, small_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        if (sum_q[MW]) begin
          sum_d   = {1'b0, sum_q[MW:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + EXP_W'(1);
          state_d = ST_DONE;
        end else if (sum_q == '0) begin
          exp_d   = '0;
          sign_d  = zsign_q;
          state_d = ST_DONE;
        end else if (sum_q[MW-1]) begin
          state_d = ST_DONE;
        end else if (exp_q <= EXP_W'(1)) begin
          exp_d   = '0;
          state_d = ST_DONE;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      big_q       <= '0;
      small_q     <= '0;
      diff_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      zsign_q     <= 1'b0;
      sum_q       <= '0;
      byp_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      big_q       <= big_d;
      small_q     <= small_d;
      diff_q      <= diff_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      sub_q       <= sub_d;
      zsign_q     <= zsign_d;
      sum_q       <= sum_d;
      byp_q       <= byp_d;
      ovf_q       <= &exp_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sign  = sign_q;
  assign out_exp   = exp_q;
  assign out_mant  = sum_q[MW-1:0];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed-vector bench for fp_add_seq (default EXP_W=8, FRAC_W=23).
module tb_fp_add_seq;

`ifdef FP_ADD_SEQ_ZERO_BYPASS_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 4;
`endif

  logic        clk, rst_n;
  logic [31:0] in_a, in_b;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        out_sign, out_ovf, busy;
  logic [7:0]  out_exp;
  logic [26:0] out_mant;

  int total = 0;
  int bad   = 0;

  fp_add_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Issue one operation and check latency and result; leaves DUT in DONE
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int lat_exp, input logic s_exp, input logic [7:0] e_exp,
                        input logic [26:0] m_exp, input logic o_exp);
    int lat;
    @(negedge clk);
    chk_eq({tag, " in_ready"}, 64'(in_ready), 64'(1));
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk_eq({tag, " busy"}, 64'({busy, in_ready}), 64'(2'b10));
      if (out_valid) break;
    end
    chk_eq({tag, " latency"}, 64'(lat), 64'(lat_exp));
    chk_eq({tag, " sign"}, 64'(out_sign), 64'(s_exp));
    chk_eq({tag, " exp"},  64'(out_exp),  64'(e_exp));
    chk_eq({tag, " mant"}, 64'(out_mant), 64'(m_exp));
    chk_eq({tag, " ovf"},  64'(out_ovf),  64'(o_exp));
  endtask

  // Complete the output handshake and confirm return to IDLE
  task automatic finish_xfer(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_eq({tag, " idle"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    int vcnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    chk_eq("reset hs", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    chk_eq("reset data", 64'({out_sign, out_exp, out_mant, out_ovf}), 64'(0));
    rst_n = 1'b1;

    run_op("one+one", 32'h3F800000, 32'h3F800000, 4, 1'b0, 8'h80, 27'h4000000, 1'b0);
    finish_xfer("one+one");
    run_op("one-one", 32'h3F800000, 32'hBF800000, 4, 1'b0, 8'h00, 27'h0000000, 1'b0);
    finish_xfer("one-one");
    run_op("diff40", 32'h3F800000, 32'h2B800000, 4, 1'b0, 8'h7F, 27'h4000001, 1'b0);
    finish_xfer("diff40");
    run_op("cancel23", 32'h3F800001, 32'hBF800000, 27, 1'b0, 8'h68, 27'h4000000, 1'b0);
    finish_xfer("cancel23");
    run_op("ovf", 32'h7F000000, 32'h7F000000, 4, 1'b0, 8'hFF, 27'h4000000, 1'b1);
    finish_xfer("ovf");
    run_op("subnorm", 32'h00000001, 32'h00000001, 4, 1'b0, 8'h00, 27'h0000010, 1'b0);
    finish_xfer("subnorm");
    run_op("one-two", 32'h3F800000, 32'hC0000000, 5, 1'b1, 8'h7F, 27'h4000000, 1'b0);
    finish_xfer("one-two");
    run_op("zero+three", 32'h00000000, 32'h40400000, ZLAT, 1'b0, 8'h80, 27'h6000000, 1'b0);
    finish_xfer("zero+three");
    run_op("three+zero", 32'h40400000, 32'h00000000, ZLAT, 1'b0, 8'h80, 27'h6000000, 1'b0);
    finish_xfer("three+zero");
    run_op("nz+nz", 32'h80000000, 32'h80000000, ZLAT, 1'b1, 8'h00, 27'h0000000, 1'b0);
    finish_xfer("nz+nz");

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    run_op("stall", 32'h3F800000, 32'h3F800000, 4, 1'b0, 8'h80, 27'h4000000, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk_eq("stall hold", 64'({out_valid, in_ready, out_sign, out_exp, out_mant}),
             64'({1'b1, 1'b0, 1'b0, 8'h80, 27'h4000000}));
    end
    finish_xfer("stall");

    // Reset in the middle of a long normalisation discards the operation
    run_op("pre-rst", 32'h3F800000, 32'h3F800000, 4, 1'b0, 8'h80, 27'h4000000, 1'b0);
    finish_xfer("pre-rst");
    @(negedge clk);
    in_a = 32'h3F800001; in_b = 32'hBF800000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("rst hs", 64'({in_ready, out_valid, busy}), 64'(3'b100));
    chk_eq("rst data", 64'({out_exp, out_mant}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk_eq("rst no output", 64'(vcnt), 64'(0));
    chk_eq("rst ready", 64'(in_ready), 64'(1));

    run_op("post-rst", 32'h3F800000, 32'hBF800000, 4, 1'b0, 8'h00, 27'h0000000, 1'b0);
    finish_xfer("post-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_add_seq.md
FP_ADD_SEQ -- requirements
Module: fp_add_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width; extended mantissa width MW = FRAC_W+4 (hidden + fraction + G/R/S).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_a, in_b  input  1+EXP_W+FRAC_W  packed IEEE-style operands {sign, exp, frac}.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1; a transfer occurs on a clk edge with both high.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1; a transfer occurs on a clk edge with both high.
REQ-008 SHALL have outputs out_sign 1, out_exp EXP_W, out_mant MW (unrounded, bit 0 = sticky), out_ovf 1 (exponent reached all-ones), busy 1.

Function
REQ-009 SHALL implement FSM IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
REQ-010 IDLE: on accept, SHALL unpack mant = {exp!=0, frac, 3'b000}, eff_exp = max(exp,1); big = larger magnitude (exp then frac; tie -> in_a); diff = eff_exp_big - eff_exp_small saturated to 63.
REQ-011 ALIGN: SHALL right-shift small mant by diff (diff >= MW -> 0), OR all shifted-out bits into bit 0; register result.
REQ-012 ADD: SHALL compute MW+1-bit sum = big+small if signs equal, else big-small; result sign = big sign.
REQ-013 NORM, one decision per cycle, priority: sum[MW] set -> shift right 1 (dropped bit ORed into bit 0), exp+1, go DONE; sum==0 -> exp 0, sign = sign_a & sign_b, go DONE; sum[MW-1] set -> DONE; exp<=1 -> exp 0 (subnormal), DONE; else shift left 1, exp-1, stay.
REQ-014 Latency: accept at edge T -> out_valid from T+4+k, k = left-shift cycles (0..MW-1).
REQ-015 out_ovf SHALL be 1 when final exp equals all-ones; no saturation, no Inf/NaN decoding (all-ones inputs processed arithmetically).
REQ-016 DONE: outputs SHALL hold stable while out_ready low; return to IDLE on transfer; no new input accepted until IDLE (one operation in flight).
REQ-017 Outputs SHALL be registered; out_* values SHALL be don't-care outside DONE but SHALL NOT glitch during DONE.

Reset
REQ-018 rst_n low SHALL immediately force state IDLE, out_valid 0, busy 0, all datapath registers and out_* to 0, in_ready 1; an in-flight operation is discarded without output.

Configuration
REQ-019 Macro FP_ADD_SEQ_ZERO_BYPASS_EN defined: if either operand has exp==0 and frac==0 at accept, SHALL skip ALIGN/ADD/NORM, load the other operand (sign = sign_a & sign_b if both zero) and enter DONE, out_valid at T+2.
REQ-020 Macro undefined: zero operands follow the normal path with REQ-014 latency.

Structure
REQ-021 Shared package fp_add_pkg SHALL hold the state enum, default EXP_W/FRAC_W, MW and the shift-saturation constant 63.
REQ-022 The right shifter with sticky SHALL be a separate combinational sub-module fp_align_shift (MW-bit data, 6-bit amount, sticky out).

Verification
REQ-023 0x3F800000 + 0x3F800000 -> out_valid at T+4, sign 0, exp 0x80, mant 0x4000000, ovf 0.
REQ-024 0x3F800000 + 0xBF800000 -> T+4, sign 0, exp 0, mant 0.
REQ-025 0x3F800000 + 0x2B800000 (diff 40) -> T+4, exp 0x7F, mant 0x4000001 (sticky set).
REQ-026 0x3F800001 + 0xBF800000 -> 23 left shifts, out_valid at T+27, exp 0x68, mant 0x4000000.
REQ-027 out_ready low 5 cycles in DONE -> outputs stable, in_ready 0, single transfer on release; rst_n pulsed during NORM -> no out_valid, in_ready 1 immediately.
REQ-028 With FP_ADD_SEQ_ZERO_BYPASS_EN: 0x00000000 + 0x40400000 -> T+2, sign 0, exp 0x80, mant 0x6000000; without macro same values at T+4.
